// File: rtl/key_switch_device_if.sv
// Processor data-memory bus as seen by the key/switch peripheral.
// The master side is the processor load/store path; the slave side is the peripheral.
interface key_switch_device_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr_in;
    logic             rd_en;
    logic             wr_en;
    logic [DBITS-1:0] data_in;
    logic [DBITS-1:0] data_out;
    logic             intr;

    modport master (
        output addr_in,
        output rd_en,
        output wr_en,
        output data_in,
        input  data_out,
        input  intr
    );

    modport slave (
        input  addr_in,
        input  rd_en,
        input  wr_en,
        input  data_in,
        output data_out,
        output intr
    );
endinterface

// File: rtl/key_switch_device.sv
// Key/switch input peripheral.
// Synchronises and debounces the board KEY and SW pins, exposes data and
// control/status registers on the data-memory bus and raises a level interrupt
// when a debounced change is pending and enabled.
module key_switch_device #(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0] KDATA_ADDR      = DBITS'(32'hF0000010),
    parameter logic [DBITS-1:0] KCTRL_ADDR      = DBITS'(32'hF0000110),
    parameter logic [DBITS-1:0] SDATA_ADDR      = DBITS'(32'hF0000014),
    parameter logic [DBITS-1:0] SCTRL_ADDR      = DBITS'(32'hF0000114)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           key_in,
    input  logic [9:0]           sw_in,
    key_switch_device_if.slave   bus
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Key group: synchroniser stages hold the pressed=1 polarity, so the
    // all-zero reset value means "no key pressed" rather than "all pressed".
    logic [3:0]       key_s1;
    logic [3:0]       key_s2;
    logic [3:0]       key_stable;
    logic [CNT_W-1:0] key_cnt;
    logic             key_event;
    logic             key_rdy;
    logic             key_ovr;
    logic             key_ie;
    logic             key_data_rd;
    logic             key_ctrl_wr;

    // Switch group
    logic [9:0]       sw_s1;
    logic [9:0]       sw_s2;
    logic [9:0]       sw_stable;
    logic [CNT_W-1:0] sw_cnt;
    logic             sw_event;
    logic             sw_rdy;
    logic             sw_ovr;
    logic             sw_ie;
    logic             sw_data_rd;
    logic             sw_ctrl_wr;

    // Bus decode; a data read only has a side effect when rd_en is high.
    assign key_data_rd = bus.rd_en && (bus.addr_in == KDATA_ADDR);
    assign key_ctrl_wr = bus.wr_en && (bus.addr_in == KCTRL_ADDR);
    assign sw_data_rd  = bus.rd_en && (bus.addr_in == SDATA_ADDR);
    assign sw_ctrl_wr  = bus.wr_en && (bus.addr_in == SCTRL_ADDR);

    // A change event fires once the synced vector has held still long enough
    // and differs from the accepted value.
    assign key_event = (key_cnt == CNT_MAX) && (key_s2 != key_stable);
    assign sw_event  = (sw_cnt  == CNT_MAX) && (sw_s2  != sw_stable);

    // Two-flop synchronisers for both pin groups (keys inverted on entry).
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1 <= '0;
            key_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            key_s1 <= ~key_in;
            key_s2 <= key_s1;
            sw_s1  <= sw_in;
            sw_s2  <= sw_s1;
        end
    end

    // Key stability counter: restarts when the synced value is about to move,
    // otherwise counts up and parks at its terminal value.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_cnt <= '0;
        end else if (key_s1 != key_s2) begin
            key_cnt <= '0;
        end else if (key_cnt != CNT_MAX) begin
            key_cnt <= key_cnt + CNT_W'(1);
        end
    end

    // Switch stability counter, same rule as the keys.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_cnt <= '0;
        end else if (sw_s1 != sw_s2) begin
            sw_cnt <= '0;
        end else if (sw_cnt != CNT_MAX) begin
            sw_cnt <= sw_cnt + CNT_W'(1);
        end
    end

    // Accept the synced vectors as the new debounced values on a change event.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_stable <= '0;
            sw_stable  <= '0;
        end else begin
            if (key_event) begin
                key_stable <= key_s2;
            end
            if (sw_event) begin
                sw_stable <= sw_s2;
            end
        end
    end

    // Key status: a new event beats a simultaneous data read, and overrun is
    // only flagged when an unread event is overwritten by a newer one.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_rdy <= 1'b0;
            key_ovr <= 1'b0;
            key_ie  <= 1'b0;
        end else begin
            if (key_event) begin
                key_rdy <= 1'b1;
            end else if (key_data_rd) begin
                key_rdy <= 1'b0;
            end

            if (key_event && key_rdy && !key_data_rd) begin
                key_ovr <= 1'b1;
            end else if (key_ctrl_wr && !bus.data_in[2]) begin
                key_ovr <= 1'b0;
            end

            if (key_ctrl_wr) begin
                key_ie <= bus.data_in[8];
            end
        end
    end

    // Switch status, same rules as the keys.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_rdy <= 1'b0;
            sw_ovr <= 1'b0;
            sw_ie  <= 1'b0;
        end else begin
            if (sw_event) begin
                sw_rdy <= 1'b1;
            end else if (sw_data_rd) begin
                sw_rdy <= 1'b0;
            end

            if (sw_event && sw_rdy && !sw_data_rd) begin
                sw_ovr <= 1'b1;
            end else if (sw_ctrl_wr && !bus.data_in[2]) begin
                sw_ovr <= 1'b0;
            end

            if (sw_ctrl_wr) begin
                sw_ie <= bus.data_in[8];
            end
        end
    end

    // Load data mux: shows the pre-edge register contents, zero when idle or unmapped.
    always_comb begin
        bus.data_out = '0;
        if (bus.rd_en) begin
            if (bus.addr_in == KDATA_ADDR) begin
                bus.data_out[3:0] = key_stable;
            end else if (bus.addr_in == KCTRL_ADDR) begin
                bus.data_out[0] = key_rdy;
                bus.data_out[2] = key_ovr;
                bus.data_out[8] = key_ie;
            end else if (bus.addr_in == SDATA_ADDR) begin
                bus.data_out[9:0] = sw_stable;
            end else if (bus.addr_in == SCTRL_ADDR) begin
                bus.data_out[0] = sw_rdy;
                bus.data_out[2] = sw_ovr;
                bus.data_out[8] = sw_ie;
            end
        end
    end

    // Level interrupt whenever an enabled group has an unread change.
    assign bus.intr = (key_rdy & key_ie) | (sw_rdy & sw_ie);

endmodule

// File: tb/tb_key_switch_device.sv
// Bench for key_switch_device with DEBOUNCE_CYCLES=4.
// A behavioural model (pin history window + register rules) predicts data_out
// and intr every cycle; directed phases pin the model with literal values,
// then a randomized phase exercises pins, bus accesses and resets together.
module tb_key_switch_device;

    localparam int          DBITS = 32;
    localparam int          DEB   = 4;
    localparam int          HIST  = 64;
    localparam logic [31:0] KDATA = 32'hF0000010;
    localparam logic [31:0] KCTRL = 32'hF0000110;
    localparam logic [31:0] SDATA = 32'hF0000014;
    localparam logic [31:0] SCTRL = 32'hF0000114;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_in;
    logic [9:0] sw_in;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    key_switch_device_if #(.DBITS(DBITS)) bus();

    key_switch_device #(
        .DBITS          (DBITS),
        .DEBOUNCE_CYCLES(DEB),
        .KDATA_ADDR     (KDATA),
        .KCTRL_ADDR     (KCTRL),
        .SDATA_ADDR     (SDATA),
        .SCTRL_ADDR     (SCTRL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_in(key_in),
        .sw_in (sw_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state. Group 0 = keys (pressed = 1), group 1 = switches.
    // mW holds the value the synchroniser presents after each edge; mRst marks reset edges.
    bit [9:0] mW [2][HIST];
    bit       mRst [HIST];
    bit [9:0] mPinPrev [2];
    bit [9:0] mStable [2];
    bit       mRdy [2];
    bit       mOvr [2];
    bit       mIe [2];
    int       mEdge = 0;
    bit [9:0] pinNow [2];
    bit       ev [2];
    bit       dataRd;
    bit       ctrlWr;

    function automatic logic [31:0] dataAddr(int g);
        return (g == 0) ? KDATA : SDATA;
    endfunction

    function automatic logic [31:0] ctrlAddr(int g);
        return (g == 0) ? KCTRL : SCTRL;
    endfunction

    // A value is accepted at edge n when the synced value was identical over the
    // last DEB samples, no reset hit the window, and it differs from the accepted one.
    function automatic bit modelEvent(int g, int n);
        bit [9:0] last;
        if (n < DEB + 1) return 1'b0;
        last = mW[g][(n - 1) % HIST];
        for (int k = n - DEB; k <= n - 1; k++) begin
            if (mW[g][k % HIST] != last) return 1'b0;
        end
        for (int k = n - DEB + 1; k <= n - 1; k++) begin
            if (mRst[k % HIST]) return 1'b0;
        end
        return last != mStable[g];
    endfunction

    function automatic logic [31:0] ctrlWord(int g);
        return {23'b0, mIe[g], 5'b0, mOvr[g], 1'b0, mRdy[g]};
    endfunction

    function automatic logic [31:0] modelRead(logic [31:0] a, logic rd);
        if (!rd)        return 32'h0;
        if (a == KDATA) return {22'b0, mStable[0]};
        if (a == KCTRL) return ctrlWord(0);
        if (a == SDATA) return {22'b0, mStable[1]};
        if (a == SCTRL) return ctrlWord(1);
        return 32'h0;
    endfunction

    // Advance the model at every rising edge from the inputs held across it.
    always @(posedge clk) begin : modelUpdate
        int n;
        n = mEdge;
        pinNow[0] = {6'b0, ~key_in};
        pinNow[1] = sw_in;
        for (int g = 0; g < 2; g++) ev[g] = modelEvent(g, n);
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                mStable[g] = '0;
                mRdy[g]    = 1'b0;
                mOvr[g]    = 1'b0;
                mIe[g]     = 1'b0;
            end else begin
                dataRd = bus.rd_en && (bus.addr_in == dataAddr(g));
                ctrlWr = bus.wr_en && (bus.addr_in == ctrlAddr(g));
                if (ev[g] && mRdy[g] && !dataRd)         mOvr[g] = 1'b1;
                else if (ctrlWr && !bus.data_in[2])      mOvr[g] = 1'b0;
                if (ev[g])                               mRdy[g] = 1'b1;
                else if (dataRd)                         mRdy[g] = 1'b0;
                if (ctrlWr)                              mIe[g]  = bus.data_in[8];
                if (ev[g])                               mStable[g] = mW[g][(n - 1) % HIST];
            end
            mW[g][n % HIST] = reset ? 10'b0 : mPinPrev[g];
            mPinPrev[g]     = reset ? 10'b0 : pinNow[g];
        end
        mRst[n % HIST] = reset;
        mEdge = mEdge + 1;
    end

    // Every cycle: bus outputs must match the model.
    always @(negedge clk) begin
        if (checkEn) begin
            testsRun++;
            if (bus.data_out !== modelRead(bus.addr_in, bus.rd_en)) begin
                testsFailed++;
                $display("[TB] FAIL data_out @%0t addr=0x%0h rd=%0b: got 0x%0h, expected 0x%0h",
                         $time, bus.addr_in, bus.rd_en, bus.data_out, modelRead(bus.addr_in, bus.rd_en));
            end
            testsRun++;
            if (bus.intr !== ((mRdy[0] & mIe[0]) | (mRdy[1] & mIe[1]))) begin
                testsFailed++;
                $display("[TB] FAIL intr @%0t: got %0b, expected %0b",
                         $time, bus.intr, (mRdy[0] & mIe[0]) | (mRdy[1] & mIe[1]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic [3:0] k, logic [9:0] s);
        key_in = k;
        sw_in  = s;
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One-cycle load: checked before the edge, side effects land on that edge.
    task automatic checkRead(string name, logic [31:0] a, logic [31:0] expected);
        bus.addr_in = a;
        bus.rd_en   = 1'b1;
        bus.wr_en   = 1'b0;
        @(negedge clk);
        checkOutput(name, bus.data_out, expected);
        tick();
        bus.rd_en   = 1'b0;
    endtask

    task automatic busWrite(logic [31:0] a, logic [31:0] d);
        bus.addr_in = a;
        bus.data_in = d;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b0;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic checkIntr(string name, logic expected);
        @(negedge clk);
        checkOutput(name, {31'b0, bus.intr}, {31'b0, expected});
        tick();
    endtask

    initial begin
        logic [31:0] addrs [5];
        logic [3:0]  k;
        logic [9:0]  s;

        reset       = 1'b1;
        applyStimulus(4'hF, 10'h0);
        bus.addr_in = '0;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.data_in = '0;
        tick();
        checkEn = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Quiet pins after reset
        repeat (20) tick();
        checkRead("reset_kctrl", KCTRL, 32'h0);
        checkRead("reset_sctrl", SCTRL, 32'h0);
        checkRead("reset_kdata", KDATA, 32'h0);
        checkRead("reset_sdata", SDATA, 32'h0);
        checkIntr("reset_intr", 1'b0);

        // Switch change accepted exactly 6 edges after the pin moves
        applyStimulus(4'hF, 10'h2A5);
        repeat (5) tick();
        checkRead("sctrl_before_event", SCTRL, 32'h0);
        checkRead("sctrl_event",        SCTRL, 32'h1);
        checkRead("sdata_event",        SDATA, 32'h2A5);
        checkRead("sctrl_after_read",   SCTRL, 32'h0);

        // Bouncing key never gets accepted
        k = 4'hF;
        for (int i = 0; i < 10; i++) begin
            k = k ^ 4'h2;
            applyStimulus(k, 10'h2A5);
            tick();
            tick();
        end
        applyStimulus(4'hF, 10'h2A5);
        repeat (10) tick();
        checkRead("bounce_kctrl", KCTRL, 32'h0);
        checkRead("bounce_kdata", KDATA, 32'h0);

        // Two unread key events -> overrun; then clear, enable and consume
        applyStimulus(4'hE, 10'h2A5);
        repeat (8) tick();
        checkRead("key_first_event", KCTRL, 32'h1);
        applyStimulus(4'hC, 10'h2A5);
        repeat (8) tick();
        checkRead("key_overrun", KCTRL, 32'h5);
        busWrite(KCTRL, 32'h0);
        checkRead("key_ovr_cleared", KCTRL, 32'h1);
        busWrite(KCTRL, 32'h100);
        checkRead("key_ie_set", KCTRL, 32'h101);
        checkIntr("intr_raised", 1'b1);
        checkRead("kdata_two_keys", KDATA, 32'h3);
        checkIntr("intr_dropped", 1'b0);
        checkRead("kctrl_after_read", KCTRL, 32'h100);

        // Event on the same edge as a data read: ready survives, no overrun
        applyStimulus(4'hC, 10'h155);
        repeat (5) tick();
        checkRead("sdata_race_old", SDATA, 32'h2A5);
        checkRead("sctrl_race",     SCTRL, 32'h1);
        checkRead("sdata_race_new", SDATA, 32'h155);

        // Reset while the counter sits at 2, then a fresh 6-edge debounce
        applyStimulus(4'hC, 10'h0F0);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkRead("sdata_after_rst",   SDATA, 32'h0);
        repeat (4) tick();
        checkRead("sctrl_before_rst_ev", SCTRL, 32'h0);
        checkRead("sctrl_rst_ev",        SCTRL, 32'h1);
        checkRead("sdata_rst_ev",        SDATA, 32'h0F0);
        checkRead("kdata_rst_ev",        KDATA, 32'h3);
        checkRead("unmapped_read",       32'hF0000018, 32'h0);
        bus.addr_in = KDATA;
        @(negedge clk);
        checkOutput("no_rd_en", bus.data_out, 32'h0);
        tick();

        // Randomized pins, bus traffic and occasional resets
        addrs[0] = KDATA;
        addrs[1] = KCTRL;
        addrs[2] = SDATA;
        addrs[3] = SCTRL;
        k = 4'hF;
        s = 10'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) k = 4'($urandom);
            if ($urandom_range(0, 9) == 0) s = 10'($urandom);
            applyStimulus(k, s);
            reset       = ($urandom_range(0, 399) == 0);
            addrs[4]    = 32'hF0000000 | 32'($urandom_range(0, 511));
            bus.addr_in = addrs[$urandom_range(0, 4)];
            bus.rd_en   = 1'($urandom);
            bus.wr_en   = ($urandom_range(0, 5) == 0);
            bus.data_in = $urandom;
            tick();
        end
        reset       = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
